// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if: PWM input and recovered-level outputs of the PWM decoder
interface pwm_decoder_if #(
    parameter int CNT_W = 16
);
    logic             pwm_in;
    logic [3:0]       level;
    logic             valid;
    logic             stuck;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] period_cycles;

    modport master (output pwm_in, input level, valid, stuck, high_cycles, period_cycles);
    modport slave  (input pwm_in, output level, valid, stuck, high_cycles, period_cycles);
endinterface

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures a PWM waveform and recovers its 16-level duty setting
module pwm_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input logic          clk,
    input logic          reset,
    pwm_decoder_if.slave bus
);
    typedef enum logic [1:0] {WAIT_FIRST, MEASURE, STUCK} state_t;

    localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);

    state_t           r_state, w_next;
    logic             r_s1, r_s2, r_prev;
    logic             w_rise, w_capture, w_to_stuck, w_ge, w_emit;
    logic [CNT_W-1:0] r_per, r_hi, r_h, r_p;
    logic [CNT_W+3:0] r_rem, w_dvs;
    logic [3:0]       r_q;
    logic [1:0]       r_step;
    logic             r_busy, r_pend;
    logic [3:0]       r_level;
    logic             r_valid, r_stuck;
    logic [CNT_W-1:0] r_high, r_period;

    assign w_rise = r_s2 & ~r_prev;
    assign w_dvs  = {4'b0, r_p} << r_step;
    assign w_ge   = r_rem >= w_dvs;
    assign w_emit = r_pend && (r_state == MEASURE);

    assign bus.level         = r_level;
    assign bus.valid         = r_valid;
    assign bus.stuck         = r_stuck;
    assign bus.high_cycles   = r_high;
    assign bus.period_cycles = r_period;

    // two-flop synchronizer plus previous-value flop for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= bus.pwm_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // period and high-time counters; the edge cycle is cycle 1 of the new period, both freeze at TIMEOUT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_per <= '0;
            r_hi  <= '0;
        end else if (w_rise) begin
            r_per <= CNT_W'(1);
            r_hi  <= CNT_W'(1);
        end else if (r_per != TO) begin
            r_per <= r_per + CNT_W'(1);
            r_hi  <= r_hi + CNT_W'(r_s2);
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= WAIT_FIRST;
        else       r_state <= w_next;
    end

    // next state; a capture needs a reference edge and an idle divider, timeout is taken one count early
    always_comb begin
        w_next     = r_state;
        w_capture  = 1'b0;
        w_to_stuck = 1'b0;
        if (r_state == STUCK) begin
            if (w_rise) w_next = MEASURE;
        end else if (w_rise) begin
            w_next    = MEASURE;
            w_capture = (r_state == MEASURE) && !r_busy;
        end else if (r_per == TO_M1) begin
            w_next     = STUCK;
            w_to_stuck = 1'b1;
        end
    end

    // restoring divider for (16*H-1)/P: shifted divisor, one quotient bit per cycle MSB first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h    <= '0;
            r_p    <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_step <= '0;
            r_busy <= 1'b0;
            r_pend <= 1'b0;
        end else if (w_capture) begin
            r_h    <= r_hi;
            r_p    <= r_per;
            r_rem  <= {r_hi, 4'b0} - (CNT_W+4)'(1);
            r_q    <= '0;
            r_step <= 2'd3;
            r_busy <= 1'b1;
            r_pend <= 1'b0;
        end else if (r_busy) begin
            if (w_ge) r_rem <= r_rem - w_dvs;
            r_q    <= {r_q[2:0], w_ge};
            r_step <= r_step - 2'd1;
            r_busy <= (r_step != 2'd0);
            r_pend <= (r_step == 2'd0);
        end else begin
            r_pend <= 1'b0;
        end
    end

    // output registers; stuck entry wins over a finishing division, whose result is dropped outside MEASURE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level  <= '0;
            r_valid  <= 1'b0;
            r_stuck  <= 1'b0;
            r_high   <= '0;
            r_period <= '0;
        end else if (w_to_stuck) begin
            r_level <= {4{r_s2}};
            r_valid <= 1'b1;
            r_stuck <= 1'b1;
        end else begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_level  <= r_q;
                r_high   <= r_h;
                r_period <= r_p;
            end
            if (r_state == STUCK && w_rise) r_stuck <= 1'b0;
        end
    end
endmodule
